// File: rtl/lwram_ctrl.sv
// LWRAM strobe responder: turns SH2-side DCE_N/DOE_N/DWE_N accesses into
// single-outstanding requests on a generic memory port. Writes are posted
// through a small FIFO. Reads hold DWAIT_N low until the data returns.
module lwram_ctrl #(
   parameter int unsigned WB_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [19:0] A,
   input  logic [15:0] DI,
   output logic [15:0] DO,
   input  logic        DCE_N,
   input  logic        DOE_N,
   input  logic [1:0]  DWE_N,
   output logic        DWAIT_N,
   output logic [19:0] MEM_A,
   output logic [15:0] MEM_D,
   output logic [1:0]  MEM_BE,
   output logic        MEM_WE,
   output logic        MEM_REQ,
   input  logic        MEM_ACK,
   input  logic [15:0] MEM_Q
);

   localparam int unsigned AW = 20;
   localparam int unsigned DW = 16;
   localparam int unsigned PW = $clog2(WB_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR_WAIT,
      ST_RD_WAIT
   } state_t;

   state_t          r_state;
   logic            r_doe_old;
   logic [1:0]      r_dwe_old;

   logic [AW-1:0]   r_wb_a  [WB_DEPTH];
   logic [DW-1:0]   r_wb_d  [WB_DEPTH];
   logic [1:0]      r_wb_be [WB_DEPTH];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;

   logic            r_hold_v;
   logic [AW-1:0]   r_hold_a;
   logic [DW-1:0]   r_hold_d;
   logic [1:0]      r_hold_be;

   logic            r_rd_pending;
   logic [AW-1:0]   r_rd_addr;

   logic            w_rd_edge;
   logic            w_wr_start;
   logic            w_rd_accept;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic            w_push_hold;
   logic            w_push_new;
   logic            w_push;
   logic            w_hold_set;
   logic [AW-1:0]   w_push_a;
   logic [DW-1:0]   w_push_d;
   logic [1:0]      w_push_be;
   logic            w_rd_done;
   logic            w_rd_pend_nxt;
   logic            w_rd_go;
   logic [AW-1:0]   w_rd_go_a;

   // Strobe edge detection; a simultaneous write edge suppresses the read,
   // and a read edge while one is already pending is dropped.
   assign w_rd_edge   = !DCE_N && !DOE_N && r_doe_old;
   assign w_wr_start  = !DCE_N && (DWE_N != 2'b11) && (r_dwe_old == 2'b11);
   assign w_rd_accept = w_rd_edge && !w_wr_start && !r_rd_pending;

   // Write buffer control; the holding register takes priority for a freed slot.
   assign w_full      = (r_count == CW'(WB_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_pop       = (r_state == ST_WR_WAIT) && MEM_ACK;
   assign w_push_hold = r_hold_v && (!w_full || w_pop);
   assign w_push_new  = w_wr_start && !r_hold_v && (!w_full || w_pop);
   assign w_hold_set  = w_wr_start && !r_hold_v && w_full && !w_pop;
   assign w_push      = w_push_hold || w_push_new;
   assign w_push_a    = r_hold_v ? r_hold_a  : A;
   assign w_push_d    = r_hold_v ? r_hold_d  : DI;
   assign w_push_be   = r_hold_v ? r_hold_be : ~DWE_N;

   // Read issue waits until every earlier write has drained.
   assign w_rd_done     = (r_state == ST_RD_WAIT) && MEM_ACK;
   assign w_rd_pend_nxt = (r_rd_pending && !w_rd_done) || w_rd_accept;
   assign w_rd_go       = (r_state == ST_IDLE) && (r_rd_pending || w_rd_accept) &&
                          w_empty && !r_hold_v && !w_push;
   assign w_rd_go_a     = w_rd_accept ? A : r_rd_addr;

   // Write buffer storage (data only, no reset needed).
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_wb_a[r_wptr]  <= w_push_a;
         r_wb_d[r_wptr]  <= w_push_d;
         r_wb_be[r_wptr] <= w_push_be;
      end
   end

   // Control state, buffer pointers, request FSM and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_doe_old    <= 1'b1;
         r_dwe_old    <= 2'b11;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_hold_v     <= 1'b0;
         r_hold_a     <= '0;
         r_hold_d     <= '0;
         r_hold_be    <= '0;
         r_rd_pending <= 1'b0;
         r_rd_addr    <= '0;
         DO           <= '0;
         DWAIT_N      <= 1'b1;
         MEM_A        <= '0;
         MEM_D        <= '0;
         MEM_BE       <= '0;
         MEM_WE       <= 1'b0;
         MEM_REQ      <= 1'b0;
      end else begin
         r_doe_old <= DOE_N;
         r_dwe_old <= DWE_N;

         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);

         if (w_hold_set) begin
            r_hold_v  <= 1'b1;
            r_hold_a  <= A;
            r_hold_d  <= DI;
            r_hold_be <= ~DWE_N;
         end else if (w_push_hold) begin
            r_hold_v  <= 1'b0;
         end

         if (w_rd_accept) r_rd_addr <= A;
         r_rd_pending <= w_rd_pend_nxt;

         // Release one cycle after the held write enters the buffer.
         DWAIT_N <= !(w_hold_set || r_hold_v || w_rd_pend_nxt);

         case (r_state)
            ST_IDLE: begin
               if (w_rd_go) begin
                  MEM_REQ <= 1'b1;
                  MEM_WE  <= 1'b0;
                  MEM_A   <= w_rd_go_a;
                  MEM_BE  <= 2'b11;
                  r_state <= ST_RD_WAIT;
               end else if (!w_empty) begin
                  MEM_REQ <= 1'b1;
                  MEM_WE  <= 1'b1;
                  MEM_A   <= r_wb_a[r_rptr];
                  MEM_D   <= r_wb_d[r_rptr];
                  MEM_BE  <= r_wb_be[r_rptr];
                  r_state <= ST_WR_WAIT;
               end
            end
            ST_WR_WAIT: begin
               if (MEM_ACK) begin
                  MEM_REQ <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_RD_WAIT: begin
               if (MEM_ACK) begin
                  DO      <= MEM_Q;
                  MEM_REQ <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lwram_ctrl.sv
// Directed bench for lwram_ctrl: reads, byte writes, buffer-full stall,
// write-then-read ordering, reset during a read and ignored strobes.
module tb_lwram_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [19:0] A;
   logic [15:0] DI;
   logic [15:0] DO;
   logic        DCE_N;
   logic        DOE_N;
   logic [1:0]  DWE_N;
   logic        DWAIT_N;
   logic [19:0] MEM_A;
   logic [15:0] MEM_D;
   logic [1:0]  MEM_BE;
   logic        MEM_WE;
   logic        MEM_REQ;
   logic        MEM_ACK;
   logic [15:0] MEM_Q;

   int n_checks = 0;
   int n_fail   = 0;

   lwram_ctrl #(.WB_DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .A(A), .DI(DI), .DO(DO),
      .DCE_N(DCE_N), .DOE_N(DOE_N), .DWE_N(DWE_N), .DWAIT_N(DWAIT_N),
      .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_BE(MEM_BE), .MEM_WE(MEM_WE),
      .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK), .MEM_Q(MEM_Q)
   );

   always #5 CLK = ~CLK;

   // One clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bounded wait for a memory request.
   task automatic wait_req(input string tag);
      int n = 0;
      while (!MEM_REQ && n < 20) begin
         tick();
         n++;
      end
      check(tag, 32'(MEM_REQ), 32'd1);
   endtask

   // Read with ACK three cycles after REQ appears.
   task automatic do_read(input string tag, input logic [19:0] addr, input logic [15:0] q);
      int low = 0;
      A = addr; DCE_N = 1'b0; DOE_N = 1'b0;
      tick();
      check({tag, "_req"}, 32'(MEM_REQ), 32'd1);
      check({tag, "_we"},  32'(MEM_WE), 32'd0);
      check({tag, "_a"},   32'(MEM_A), 32'(addr));
      check({tag, "_be"},  32'(MEM_BE), 32'd3);
      repeat (3) begin
         if (!DWAIT_N) low++;
         tick();
      end
      if (!DWAIT_N) low++;
      check({tag, "_req_hold"}, 32'(MEM_REQ), 32'd1);
      MEM_ACK = 1'b1; MEM_Q = q;
      tick();
      MEM_ACK = 1'b0;
      check({tag, "_wait_rel"}, 32'(DWAIT_N), 32'd1);
      check({tag, "_do"},       32'(DO), 32'(q));
      check({tag, "_low_cyc"},  32'(low), 32'd4);
      check({tag, "_req_drop"}, 32'(MEM_REQ), 32'd0);
      DCE_N = 1'b1; DOE_N = 1'b1;
      tick();
   endtask

   initial begin
      logic [15:0] wdat [5];
      int stall_low;
      RST = 1'b1; A = '0; DI = '0; DCE_N = 1'b1; DOE_N = 1'b1; DWE_N = 2'b11;
      MEM_ACK = 1'b0; MEM_Q = '0;
      tick(); tick();
      check("rst_dwait", 32'(DWAIT_N), 32'd1);
      check("rst_do",    32'(DO), 32'd0);
      check("rst_req",   32'(MEM_REQ), 32'd0);
      check("rst_memab", {MEM_A[15:0], MEM_D}, 32'd0);
      check("rst_bewe",  {29'd0, MEM_BE, MEM_WE}, 32'd0);
      RST = 1'b0;
      tick();

      // Single read
      do_read("rd1", 20'h00123, 16'hBEEF);

      // Byte write (low byte)
      A = 20'h00040; DI = 16'h1234; DCE_N = 1'b0; DWE_N = 2'b10;
      tick();
      check("bw_dwait0", 32'(DWAIT_N), 32'd1);
      DWE_N = 2'b11; DCE_N = 1'b1;
      tick();
      check("bw_req",   32'(MEM_REQ), 32'd1);
      check("bw_we",    32'(MEM_WE), 32'd1);
      check("bw_be",    32'(MEM_BE), 32'd1);
      check("bw_d",     32'(MEM_D), 32'h1234);
      check("bw_a",     32'(MEM_A), 32'h40);
      check("bw_dwait1", 32'(DWAIT_N), 32'd1);
      MEM_ACK = 1'b1;
      tick();
      MEM_ACK = 1'b0;
      check("bw_req_drop", 32'(MEM_REQ), 32'd0);
      tick();

      // Five back-to-back writes with ACK withheld
      wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333;
      wdat[3] = 16'h4444; wdat[4] = 16'h5555;
      stall_low = 0;
      for (int i = 0; i < 5; i++) begin
         A = 20'(32'h100 + i); DI = wdat[i]; DCE_N = 1'b0; DWE_N = 2'b00;
         tick();
         DWE_N = 2'b11; DCE_N = 1'b1;
         if (i < 4 && !DWAIT_N) stall_low++;
         tick();
         if (i < 4 && !DWAIT_N) stall_low++;
      end
      check("wb_no_early_stall", 32'(stall_low), 32'd0);
      check("wb_full_stall", 32'(DWAIT_N), 32'd0);
      check("wb_head_a",  32'(MEM_A), 32'h100);
      check("wb_head_d",  32'(MEM_D), 32'h1111);
      check("wb_head_be", 32'(MEM_BE), 32'd3);
      MEM_ACK = 1'b1;
      tick();
      MEM_ACK = 1'b0;
      check("wb_stall_p1", 32'(DWAIT_N), 32'd0);
      tick();
      check("wb_stall_rel", 32'(DWAIT_N), 32'd1);
      for (int i = 1; i < 5; i++) begin
         wait_req($sformatf("wb_req%0d", i));
         check($sformatf("wb_a%0d", i),  32'(MEM_A), 32'h100 + 32'(i));
         check($sformatf("wb_d%0d", i),  32'(MEM_D), 32'(wdat[i]));
         check($sformatf("wb_we%0d", i), 32'(MEM_WE), 32'd1);
         MEM_ACK = 1'b1;
         tick();
         MEM_ACK = 1'b0;
      end
      tick();
      check("wb_drained", 32'(MEM_REQ), 32'd0);

      // Write then immediate read of the same address
      A = 20'h00005; DI = 16'hAAAA; DCE_N = 1'b0; DWE_N = 2'b00;
      tick();
      DWE_N = 2'b11; DOE_N = 1'b0;
      tick();
      check("raw_wr_first", {30'd0, MEM_REQ, MEM_WE}, 32'd3);
      check("raw_wr_a",     32'(MEM_A), 32'h5);
      check("raw_wait",     32'(DWAIT_N), 32'd0);
      MEM_ACK = 1'b1;
      tick();
      MEM_ACK = 1'b0;
      check("raw_gap", 32'(MEM_REQ), 32'd0);
      tick();
      check("raw_rd_req", {30'd0, MEM_REQ, MEM_WE}, 32'd2);
      check("raw_rd_a",   32'(MEM_A), 32'h5);
      MEM_ACK = 1'b1; MEM_Q = 16'hAAAA;
      tick();
      MEM_ACK = 1'b0;
      check("raw_do",    32'(DO), 32'hAAAA);
      check("raw_dwait", 32'(DWAIT_N), 32'd1);
      DCE_N = 1'b1; DOE_N = 1'b1;
      tick();

      // Reset while a read is outstanding
      A = 20'h00077; DCE_N = 1'b0; DOE_N = 1'b0;
      tick();
      check("rr_req", 32'(MEM_REQ), 32'd1);
      tick();
      RST = 1'b1; DCE_N = 1'b1; DOE_N = 1'b1;
      tick();
      check("rr_req_drop", 32'(MEM_REQ), 32'd0);
      check("rr_dwait",    32'(DWAIT_N), 32'd1);
      RST = 1'b0; MEM_ACK = 1'b1; MEM_Q = 16'hDEAD;
      tick();
      MEM_ACK = 1'b0;
      check("rr_late_do",  32'(DO), 32'd0);
      check("rr_late_req", 32'(MEM_REQ), 32'd0);
      check("rr_late_dw",  32'(DWAIT_N), 32'd1);
      tick();
      do_read("rd2", 20'h00123, 16'h1357);

      // Strobes with DCE_N high are ignored
      stall_low = 0;
      DCE_N = 1'b1;
      for (int i = 0; i < 8; i++) begin
         DOE_N = i[0];
         DWE_N = 2'(i >> 1);
         tick();
         if (MEM_REQ || !DWAIT_N) stall_low++;
      end
      DOE_N = 1'b1; DWE_N = 2'b11;
      repeat (3) begin
         tick();
         if (MEM_REQ || !DWAIT_N) stall_low++;
      end
      check("dce_ignored", 32'(stall_low), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
